obi_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one OBI slave port between NUM_REQ OBI masters, for example core instruction fetch and LSU. The shared port typically feeds a single OBI-to-AXI bridge. It tracks granted transactions in an in-order ID FIFO so each response is returned to the master that issued it. It supports up to MAX_OUTSTANDING pipelined transactions and keeps slave-side request signals stable until grant, as OBI requires.

---
 rtl/obi_rr_arbiter.sv | 176 +++++++++++++++++
 tb/tb_obi_rr_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/obi_rr_arbiter.sv
// obi_rr_arbiter: round-robin arbiter that shares one OBI slave port between
// NUM_REQ OBI masters. An in-order ID FIFO records which master owns each
// granted transaction, so every response goes back to the master that issued it.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   m_req_i / m_gnt_o        per-master request / grant (grant one-hot or zero)
//   m_we_i, m_be_i,
//   m_addr_i, m_wdata_i      per-master address phase, packed master-major
//   m_rvalid_o, m_rdata_o    per-master response valid, broadcast read data
//   s_req_o .. s_wdata_o     shared slave address phase
//   s_gnt_i                  slave grant
//   s_rvalid_i, s_rdata_i    slave response
//   outstanding_o            granted-but-unanswered transaction count
//   err_rvalid_o             sticky: response arrived with nothing outstanding
module obi_rr_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NUM_REQ-1:0]                  m_req_i,
    output logic [NUM_REQ-1:0]                  m_gnt_o,
    output logic [NUM_REQ-1:0]                  m_rvalid_o,
    input  logic [NUM_REQ-1:0]                  m_we_i,
    input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]   m_be_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       m_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]       m_wdata_i,
    output logic [DATA_WIDTH-1:0]               m_rdata_o,
    output logic                                s_req_o,
    output logic                                s_we_o,
    output logic [DATA_WIDTH/8-1:0]             s_be_o,
    output logic [ADDR_WIDTH-1:0]               s_addr_o,
    output logic [DATA_WIDTH-1:0]               s_wdata_o,
    input  logic                                s_gnt_i,
    input  logic                                s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]               s_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING):0]    outstanding_o,
    output logic                                err_rvalid_o
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned BeW  = DATA_WIDTH / 8;
    localparam int unsigned PtrW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]   lock_idx_q, lock_idx_d;
    logic [IdxW-1:0]   fifo_q [MAX_OUTSTANDING];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;
    logic              err_q;

    logic [BeW-1:0]        be_arr    [NUM_REQ];
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign be_arr[g]    = m_be_i[g*BeW +: BeW];
        assign addr_arr[g]  = m_addr_i[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[g] = m_wdata_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    logic            full;
    logic            arb_found;
    logic [IdxW-1:0] arb_sel;
    logic [IdxW:0]   cand_sum;
    logic [IdxW-1:0] cur;
    logic            req_active;
    logic            push;
    logic            pop;

    assign full = (count_q == CntW'(MAX_OUTSTANDING));

    always_comb begin
        arb_found  = 1'b0;
        arb_sel    = '0;
        cand_sum   = '0;
        cur        = '0;
        req_active = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        lock_idx_d = lock_idx_q;
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_be_o     = '0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;

        // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
            if (cand_sum >= (IdxW+1)'(NUM_REQ)) begin
                cand_sum = cand_sum - (IdxW+1)'(NUM_REQ);
            end
            if (!arb_found && m_req_i[cand_sum[IdxW-1:0]]) begin
                arb_found = 1'b1;
                arb_sel   = cand_sum[IdxW-1:0];
            end
        end

        // Locked phase keeps the pending master so s_* stay stable until grant.
        cur = (state_q == StLocked) ? lock_idx_q : arb_sel;
        // Gating with rst_ni keeps every output at zero while reset is held.
        req_active = rst_ni && ((state_q == StLocked) || (arb_found && !full));

        if (req_active) begin
            s_req_o   = 1'b1;
            s_we_o    = m_we_i[cur];
            s_be_o    = be_arr[cur];
            s_addr_o  = addr_arr[cur];
            s_wdata_o = wdata_arr[cur];
        end

        push = req_active && s_gnt_i;
        if (push) begin
            m_gnt_o[cur] = 1'b1;
            rr_ptr_d     = (cur == IdxW'(NUM_REQ - 1)) ? '0 : cur + 1'b1;
            state_d      = StIdle;
        end else if (req_active && state_q == StIdle) begin
            lock_idx_d = cur;
            state_d    = StLocked;
        end

        pop = rst_ni && s_rvalid_i && (count_q != '0);
        if (pop) begin
            m_rvalid_o[fifo_q[rd_ptr_q]] = 1'b1;
        end

        count_d = count_q + CntW'(push) - CntW'(pop);
    end

    assign m_rdata_o     = s_rdata_i;
    assign outstanding_o = count_q;
    assign err_rvalid_o  = err_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
            count_q    <= count_d;
            if (push) begin
                fifo_q[wr_ptr_q] <= cur;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (s_rvalid_i && count_q == '0) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_obi_rr_arbiter.sv
module tb_obi_rr_arbiter;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MO = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [1:0]        m_req_i;
    logic [1:0]        m_gnt_o;
    logic [1:0]        m_rvalid_o;
    logic [1:0]        m_we_i;
    logic [7:0]        m_be_i;
    logic [63:0]       m_addr_i;
    logic [63:0]       m_wdata_i;
    logic [DW-1:0]     m_rdata_o;
    logic              s_req_o;
    logic              s_we_o;
    logic [3:0]        s_be_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_wdata_o;
    logic              s_gnt_i;
    logic              s_rvalid_i;
    logic [DW-1:0]     s_rdata_i;
    logic [2:0]        outstanding_o;
    logic              err_rvalid_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    obi_rr_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .m_req_i(m_req_i), .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o),
        .m_we_i(m_we_i), .m_be_i(m_be_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_rdata_o(m_rdata_o),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_be_o(s_be_o), .s_addr_o(s_addr_o),
        .s_wdata_o(s_wdata_o), .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i),
        .s_rdata_i(s_rdata_i), .outstanding_o(outstanding_o), .err_rvalid_o(err_rvalid_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Apply inputs, let combinational paths settle.
    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic [31:0] rdata);
        m_req_i    = req;
        s_gnt_i    = gnt;
        s_rvalid_i = rv;
        s_rdata_i  = rdata;
        #1;
    endtask

    logic [1:0] exp_gnt [4];

    initial begin
        rst_ni     = 1'b0;
        m_req_i    = '0;
        s_gnt_i    = 1'b0;
        s_rvalid_i = 1'b0;
        s_rdata_i  = '0;
        m_we_i     = 2'b01;
        m_be_i     = {4'h3, 4'hF};
        m_addr_i   = {32'h0000_2000, 32'h0000_1000};
        m_wdata_i  = {32'hBBBB_0001, 32'hAAAA_0000};
        exp_gnt    = '{2'b01, 2'b10, 2'b01, 2'b10};

        // Reset state
        #3;
        check("rst_sreq", s_req_o, 0);
        check("rst_gnt", m_gnt_o, 0);
        check("rst_rvalid", m_rvalid_o, 0);
        check("rst_cnt", outstanding_o, 0);
        check("rst_err", err_rvalid_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        drive(2'b00, 1'b0, 1'b0, 0);
        check("idle_sreq", s_req_o, 0);
        check("idle_addr", s_addr_o, 0);

        // Fairness: both request, response one cycle after each grant
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 1'b1, (i > 0), 32'h100 + i);
            check("fair_gnt", m_gnt_o, exp_gnt[i]);
            check("fair_addr", s_addr_o, (i % 2 == 0) ? 32'h1000 : 32'h2000);
            check("fair_rvalid", m_rvalid_o, (i == 0) ? 2'b00 : exp_gnt[i-1]);
            check("fair_cnt", outstanding_o, (i == 0) ? 0 : 1);
            step();
        end
        drive(2'b00, 1'b0, 1'b1, 32'h104);
        check("fair_drain", m_rvalid_o, 2'b10);
        step();
        check("fair_empty", outstanding_o, 0);

        // Lock: master 1 waits for grant, master 0 joins while locked
        for (int i = 0; i < 3; i++) begin
            drive(2'b10, 1'b0, 1'b0, 0);
            check("lock_req", s_req_o, 1);
            check("lock_gnt0", m_gnt_o, 0);
            step();
        end
        drive(2'b11, 1'b0, 1'b0, 0);
        check("lock_addr", s_addr_o, 32'h2000);
        check("lock_we", s_we_o, 0);
        check("lock_be", s_be_o, 4'h3);
        step();
        drive(2'b11, 1'b1, 1'b0, 0);
        check("lock_addr_g", s_addr_o, 32'h2000);
        check("lock_gnt", m_gnt_o, 2'b10);
        step();
        drive(2'b11, 1'b1, 1'b0, 0);
        check("lock_next", m_gnt_o, 2'b01);
        check("lock_next_wd", s_wdata_o, 32'hAAAA_0000);
        step();
        drive(2'b00, 1'b0, 1'b1, 0);
        check("lock_rv1", m_rvalid_o, 2'b10);
        step();
        drive(2'b00, 1'b0, 1'b1, 0);
        check("lock_rv0", m_rvalid_o, 2'b01);
        step();
        check("lock_empty", outstanding_o, 0);

        // Full stall: four grants, then gated
        for (int i = 0; i < 4; i++) begin
            drive(2'b01, 1'b1, 1'b0, 0);
            check("full_gnt", m_gnt_o, 2'b01);
            check("full_cnt", outstanding_o, i);
            step();
        end
        drive(2'b01, 1'b1, 1'b0, 0);
        check("full_sreq", s_req_o, 0);
        check("full_gnt_off", m_gnt_o, 0);
        check("full_cnt4", outstanding_o, 4);
        step();
        drive(2'b01, 1'b1, 1'b1, 0);
        check("full_rv", m_rvalid_o, 2'b01);
        check("full_still", m_gnt_o, 0);
        step();
        drive(2'b01, 1'b1, 1'b0, 0);
        check("full_cnt3", outstanding_o, 3);
        check("full_resume", m_gnt_o, 2'b01);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 1'b0, 1'b1, 0);
            check("full_drain", m_rvalid_o, 2'b01);
            step();
        end
        check("full_empty", outstanding_o, 0);

        // Ordering: grants 1,0,1; third grant overlaps first response
        drive(2'b11, 1'b1, 1'b0, 0);
        check("ord_g1", m_gnt_o, 2'b10);
        step();
        drive(2'b11, 1'b1, 1'b0, 0);
        check("ord_g0", m_gnt_o, 2'b01);
        step();
        drive(2'b11, 1'b1, 1'b1, 32'hAAAA_AAAA);
        check("ord_g1b", m_gnt_o, 2'b10);
        check("ord_rvA", m_rvalid_o, 2'b10);
        check("ord_dA", m_rdata_o, 32'hAAAA_AAAA);
        check("ord_cnt_pre", outstanding_o, 2);
        step();
        drive(2'b00, 1'b0, 1'b1, 32'hBBBB_BBBB);
        check("ord_cnt_same", outstanding_o, 2);
        check("ord_rvB", m_rvalid_o, 2'b01);
        check("ord_dB", m_rdata_o, 32'hBBBB_BBBB);
        step();
        drive(2'b00, 1'b0, 1'b1, 32'hCCCC_CCCC);
        check("ord_rvC", m_rvalid_o, 2'b10);
        check("ord_dC", m_rdata_o, 32'hCCCC_CCCC);
        step();
        drive(2'b00, 1'b0, 1'b0, 0);
        check("ord_empty", outstanding_o, 0);

        // Reset mid-cycle with a transaction outstanding
        drive(2'b01, 1'b1, 1'b0, 0);
        step();
        drive(2'b11, 1'b0, 1'b0, 0);
        check("mid_cnt_pre", outstanding_o, 1);
        rst_ni = 1'b0;
        #1;
        check("mid_cnt", outstanding_o, 0);
        check("mid_sreq", s_req_o, 0);
        check("mid_addr", s_addr_o, 0);
        step();
        drive(2'b00, 1'b0, 1'b0, 0);
        rst_ni = 1'b1;
        step();

        // Spurious response (e.g. the one cancelled by reset)
        drive(2'b00, 1'b0, 1'b1, 32'h1234);
        check("spur_rv", m_rvalid_o, 0);
        step();
        drive(2'b00, 1'b0, 1'b0, 0);
        check("spur_err", err_rvalid_o, 1);
        check("spur_cnt", outstanding_o, 0);
        step();
        step();
        check("spur_sticky", err_rvalid_o, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
